// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/exec memory bus arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned WADR_W = 19;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    ACK  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_E = 1'b1
  } owner_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;
  localparam logic [1:0] SEL_W    = 2'b11;

  // Transaction latched at grant time.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              byte_acc;
    logic [DATA_W-1:0] wdata;
  } xfer_t;

  // A word access at an odd address needs two byte cycles.
  function automatic logic is_split(input logic [ADDR_W-1:0] addr, input logic byte_acc);
    return addr[0] & ~byte_acc;
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_lane_mux.sv
// Byte-lane steering: write-data placement and read-data assembly.
module mem_arbiter_byte_lane_mux
  import mem_arbiter_pkg::*;
(
  input  logic              off,
  input  logic              byte_acc,
  input  logic              wphase,
  input  logic              rphase,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdat,
  input  logic [7:0]        partial,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] wdat,
  output logic [DATA_W-1:0] rdata
);

  // wphase selects the bus cycle being set up, rphase the one completing.
  always_comb begin
    sel   = SEL_W;
    wdat  = wdata;
    rdata = rdat;
    if (byte_acc) begin
      sel   = off ? SEL_HI : SEL_LO;
      wdat  = {wdata[7:0], wdata[7:0]};
      rdata = {8'h00, (off ? rdat[15:8] : rdat[7:0])};
    end else if (off) begin
      sel   = wphase ? SEL_LO : SEL_HI;
      wdat  = wphase ? {wdata[15:8], wdata[15:8]} : {wdata[7:0], wdata[7:0]};
      rdata = rphase ? {rdat[7:0], partial} : {8'h00, rdat[15:8]};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the 16-bit memory bus between fetch and exec, splitting odd word accesses.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_byte,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              e_req,
  input  logic              e_we,
  input  logic [ADDR_W-1:0] e_addr,
  input  logic              e_byte,
  input  logic [DATA_W-1:0] e_wdata,
  output logic              e_ack,
  output logic [DATA_W-1:0] e_rdata,
  output logic              m_cyc,
  output logic              m_we,
  output logic [WADR_W-1:0] m_adr,
  output logic [1:0]        m_sel,
  output logic [DATA_W-1:0] m_wdat,
  input  logic [DATA_W-1:0] m_rdat,
  input  logic              m_ack
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t            state;
  owner_t            owner;
  xfer_t             cur;
  xfer_t             req_x;
  logic [CNT_W-1:0]  starve;
  logic [7:0]        partial;

  logic              fetch_wins;
  logic              last_beat;
  logic              src_off;
  logic              src_byte;
  logic [DATA_W-1:0] src_wdata;
  logic [WADR_W-1:0] next_wadr;
  logic [1:0]        nxt_sel;
  logic [DATA_W-1:0] nxt_wdat;
  logic [DATA_W-1:0] rd_val;

  // Grant candidate and lane-mux source: live request in IDLE, latched transaction otherwise.
  always_comb begin
    fetch_wins = f_req && (!e_req || (starve == LIMIT));
    if (fetch_wins) begin
      req_x.we       = 1'b0;
      req_x.addr     = f_addr;
      req_x.byte_acc = f_byte;
      req_x.wdata    = DATA_W'(0);
    end else begin
      req_x.we       = e_we;
      req_x.addr     = e_addr;
      req_x.byte_acc = e_byte;
      req_x.wdata    = e_wdata;
    end
    src_off   = (state == IDLE) ? req_x.addr[0]   : cur.addr[0];
    src_byte  = (state == IDLE) ? req_x.byte_acc  : cur.byte_acc;
    src_wdata = (state == IDLE) ? req_x.wdata     : cur.wdata;
    last_beat = (state == ACC2) || !is_split(cur.addr, cur.byte_acc);
    next_wadr = cur.addr[ADDR_W-1:1] + WADR_W'(1);
  end

  mem_arbiter_byte_lane_mux u_byte_lane_mux (
    .off      (src_off),
    .byte_acc (src_byte),
    .wphase   (state == ACC1),
    .rphase   (state == ACC2),
    .wdata    (src_wdata),
    .rdat     (m_rdat),
    .partial  (partial),
    .sel      (nxt_sel),
    .wdat     (nxt_wdat),
    .rdata    (rd_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= OWN_F;
      cur     <= '0;
      starve  <= '0;
      partial <= '0;
      f_ack   <= 1'b0;
      e_ack   <= 1'b0;
      f_rdata <= '0;
      e_rdata <= '0;
      m_cyc   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= '0;
      m_sel   <= SEL_NONE;
      m_wdat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (f_req || e_req) begin
            cur   <= req_x;
            owner <= fetch_wins ? OWN_F : OWN_E;
            if (fetch_wins) begin
              starve <= '0;
            end else if (f_req && (starve != LIMIT)) begin
              starve <= starve + CNT_W'(1);
            end
            m_cyc  <= 1'b1;
            m_we   <= req_x.we;
            m_adr  <= req_x.addr[ADDR_W-1:1];
            m_sel  <= nxt_sel;
            m_wdat <= nxt_wdat;
            state  <= ACC1;
          end
        end
        ACC1, ACC2: begin
          if (m_ack) begin
            if (!last_beat) begin
              // Second half of an odd word: stay on the bus, move to the next word.
              state   <= ACC2;
              m_adr   <= next_wadr;
              m_sel   <= nxt_sel;
              m_wdat  <= nxt_wdat;
              partial <= rd_val[7:0];
            end else begin
              state <= ACK;
              m_cyc <= 1'b0;
              m_we  <= 1'b0;
              m_sel <= SEL_NONE;
              if (owner == OWN_F) begin
                f_ack <= 1'b1;
                if (!cur.we) f_rdata <= rd_val;
              end else begin
                e_ack <= 1'b1;
                if (!cur.we) e_rdata <= rd_val;
              end
            end
          end
        end
        ACK: begin
          f_ack <= 1'b0;
          e_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
